// File: rtl/wf_capture_seq.sv
// Round-robin capture sequencer sharing one IQ sampler write port among NWF CIC channels.
// Optional CIC settling flush after each sampler reset: define WF_CAPTURE_FLUSH_EN.
module wf_capture_seq #(
  parameter  int NWF     = 4,
  parameter  int DEPTH   = 1024,
  parameter  int FLUSH_N = 8,
  localparam int SELW    = (NWF > 1) ? $clog2(NWF) : 1
) (
  input  logic            adc_clk,
  input  logic            rst_A,
  input  logic [NWF-1:0]  start_A,
  input  logic [NWF-1:0]  contin_A,
  input  logic [NWF-1:0]  avail_A,
  output logic            samp_rst_A,
  output logic            samp_wr_A,
  output logic [SELW-1:0] samp_sel_A,
  output logic [NWF-1:0]  done_A,
  output logic            busy_A,
  output logic [NWF-1:0]  pend_A
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RST   = 3'd1;
`ifdef WF_CAPTURE_FLUSH_EN
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [7:0] FL_LAST = 8'(FLUSH_N - 1);
`endif
  localparam logic [2:0] S_CAP   = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  if (NWF < 1 || NWF > 8 || DEPTH < 2 || DEPTH > 8192 || (DEPTH & (DEPTH - 1)) != 0 ||
      FLUSH_N < 1 || FLUSH_N > 255) begin : g_param_chk
    $error("wf_capture_seq: parameter out of range");
  end

  logic [2:0]      state;
  logic [SELW-1:0] last;
  logic [CW-1:0]   cnt;
`ifdef WF_CAPTURE_FLUSH_EN
  logic [7:0]      fcnt;
`endif

  logic            avail_sel;
  logic            gnt_found;
  logic [SELW-1:0] gnt_idx;
  logic [NWF-1:0]  take;

  assign avail_sel = avail_A[samp_sel_A];

  // Scan from last+1 around the ring; the first pending channel wins.
  always_comb begin
    logic [SELW-1:0] ci;
    int c;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    ci        = '0;
    c         = 0;
    for (int i = 1; i <= NWF; i++) begin
      c = int'(last) + i;
      if (c >= NWF) c = c - NWF;
      ci = SELW'(c);
      if (!gnt_found && pend_A[ci]) begin
        gnt_found = 1'b1;
        gnt_idx   = ci;
      end
    end
  end

  always_comb begin
    take = '0;
    if (state == S_IDLE && gnt_found) take[gnt_idx] = 1'b1;
  end

  // A start coinciding with its own grant wins, re-queuing the channel.
  always_ff @(posedge adc_clk) begin
    if (rst_A) pend_A <= '0;
    else       pend_A <= (pend_A & ~take) | start_A;
  end

  always_ff @(posedge adc_clk) begin
    if (rst_A) begin
      state      <= S_IDLE;
      samp_sel_A <= '0;
      last       <= SELW'(NWF - 1);
      cnt        <= '0;
`ifdef WF_CAPTURE_FLUSH_EN
      fcnt       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (gnt_found) begin
          samp_sel_A <= gnt_idx;
          last       <= gnt_idx;
          state      <= S_RST;
        end
        S_RST: begin
          cnt   <= '0;
`ifdef WF_CAPTURE_FLUSH_EN
          fcnt  <= '0;
          state <= S_FLUSH;
`else
          state <= S_CAP;
`endif
        end
`ifdef WF_CAPTURE_FLUSH_EN
        S_FLUSH: if (avail_sel) begin
          if (fcnt == FL_LAST) begin
            fcnt  <= '0;
            cnt   <= '0;
            state <= S_CAP;
          end else begin
            fcnt  <= fcnt + 8'd1;
          end
        end
`endif
        S_CAP: if (avail_sel) begin
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) state <= S_FIN;
        end
        // Continuous wrap re-enters CAP without a sampler reset or flush.
        S_FIN: begin
          if (contin_A[samp_sel_A]) begin
            cnt   <= '0;
            state <= S_CAP;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign samp_rst_A = (state == S_RST);
  assign samp_wr_A  = (state == S_CAP) && avail_sel;
  assign busy_A     = (state != S_IDLE);

  always_comb begin
    done_A = '0;
    if (state == S_FIN) done_A[samp_sel_A] = 1'b1;
  end

endmodule

// File: tb/tb_wf_capture_seq.sv
// Scoreboard bench for wf_capture_seq: stimulus queues expected sampler events, a monitor pops them.
module tb_wf_capture_seq;
  localparam int NWF = 4, DEPTH = 16, FLUSH_N = 4, SELW = 2;
`ifdef WF_CAPTURE_FLUSH_EN
  localparam int FL = FLUSH_N;
`else
  localparam int FL = 0;
`endif
  localparam int K_RST = 1, K_WR = 2, K_DONE = 3;

  logic            adc_clk = 1'b0;
  logic            rst_A = 1'b1;
  logic [NWF-1:0]  start_A = '0, contin_A = '0, avail_A = '0;
  logic            samp_rst_A, samp_wr_A, busy_A;
  logic [SELW-1:0] samp_sel_A;
  logic [NWF-1:0]  done_A, pend_A;

  int pass_cnt = 0, tot_cnt = 0;
  int expq[$];

  wf_capture_seq #(.NWF(NWF), .DEPTH(DEPTH), .FLUSH_N(FLUSH_N)) dut (
    .adc_clk(adc_clk), .rst_A(rst_A), .start_A(start_A), .contin_A(contin_A),
    .avail_A(avail_A), .samp_rst_A(samp_rst_A), .samp_wr_A(samp_wr_A),
    .samp_sel_A(samp_sel_A), .done_A(done_A), .busy_A(busy_A), .pend_A(pend_A));

  always #5 adc_clk = ~adc_clk;

  task automatic chk(input string name, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push(input int kind, input int data, input int n);
    for (int i = 0; i < n; i++) expq.push_back(kind * 256 + data);
  endtask

  task automatic see(input int kind, input int data);
    int e;
    if (expq.size() == 0) begin
      tot_cnt++;
      $display("FAIL unexpected_event: got kind %0d data %0d expected none", kind, data);
    end else begin
      e = expq.pop_front();
      chk("sb_event(kind*256+data)", kind * 256 + data, e);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge adc_clk);
      if (samp_rst_A)  see(K_RST, int'(samp_sel_A));
      if (samp_wr_A)   see(K_WR, int'(samp_sel_A));
      if (|done_A)     see(K_DONE, int'(done_A));
    end
  endtask

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic strobe(input logic [NWF-1:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      avail_A = m; tick(); avail_A = '0; tick(); tick();
    end
  endtask

  task automatic start_ch(input logic [NWF-1:0] m);
    start_A = m; tick(); start_A = '0;
  endtask

  task automatic wait_idle(input string name, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (!busy_A) break;
      tick();
    end
    chk(name, int'(busy_A), 0);
  endtask

  task automatic do_reset();
    rst_A = 1'b1; tick(); tick(); rst_A = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_busy", int'(busy_A), 0);
    chk("rst_pend", int'(pend_A), 0);
    chk("rst_sel", int'(samp_sel_A), 0);
    chk("rst_samp_rst", int'(samp_rst_A), 0);
    chk("rst_wr", int'(samp_wr_A), 0);
    chk("rst_done", int'(done_A), 0);
    fork monitor(); join_none

    // single capture on channel 0
    push(K_RST, 0, 1); push(K_WR, 0, DEPTH); push(K_DONE, 1, 1);
    start_ch(4'b0001);
    chk("t1_pend_set", int'(pend_A), 1);
    chk("t1_busy_pre", int'(busy_A), 0);
    tick();
    chk("t1_samp_rst_lat", int'(samp_rst_A), 1);
    chk("t1_pend_clr", int'(pend_A), 0);
    tick();
    strobe(4'b0001, FL + DEPTH);
    wait_idle("t1_idle", 50);
    chk("t1_q_empty", expq.size(), 0);

    // round robin 0,2,3 from reset
    do_reset();
    push(K_RST, 0, 1); push(K_WR, 0, DEPTH); push(K_DONE, 1, 1);
    push(K_RST, 2, 1); push(K_WR, 2, DEPTH); push(K_DONE, 4, 1);
    push(K_RST, 3, 1); push(K_WR, 3, DEPTH); push(K_DONE, 8, 1);
    start_ch(4'b1101);
    chk("t2_pend_all", int'(pend_A), 13);
    tick();
    chk("t2_pend_after_g0", int'(pend_A), 12);
    strobe(4'b1111, 3 * (FL + DEPTH) + 8);
    wait_idle("t2_idle", 200);
    chk("t2_pend_end", int'(pend_A), 0);
    chk("t2_q_empty", expq.size(), 0);

    // continuous on channel 1, drop contin after write 20
    push(K_RST, 1, 1); push(K_WR, 1, DEPTH); push(K_DONE, 2, 1);
    push(K_WR, 1, DEPTH); push(K_DONE, 2, 1);
    contin_A = 4'b0010;
    start_ch(4'b0010);
    tick(); tick();
    for (int i = 1; i <= FL + 40; i++) begin
      avail_A = 4'b0010; tick(); avail_A = '0;
      if (i == FL + 20) contin_A = '0;
      tick(); tick();
    end
    wait_idle("t3_idle", 50);
    chk("t3_q_empty", expq.size(), 0);

    // foreign strobes must not write or advance the count
    push(K_RST, 0, 1); push(K_WR, 0, DEPTH); push(K_DONE, 1, 1);
    start_ch(4'b0001);
    tick(); tick();
    for (int i = 0; i < 40; i++) begin
      avail_A = (i % 2 == 0) ? 4'b1110 : 4'b0000; tick();
    end
    avail_A = '0;
    chk("t4_still_busy", int'(busy_A), 1);
    chk("t4_q_after_foreign", expq.size(), DEPTH + 1);
    strobe(4'b0001, FL + DEPTH);
    wait_idle("t4_idle", 50);
    chk("t4_q_empty", expq.size(), 0);

    // reset after 7 writes, start in the reset cycle is lost
    push(K_RST, 0, 1); push(K_WR, 0, 7);
    start_ch(4'b0001);
    tick(); tick();
    strobe(4'b0001, FL + 7);
    rst_A = 1'b1; start_A = 4'b0100; tick(); rst_A = 1'b0; start_A = '0;
    chk("t5_busy_rst", int'(busy_A), 0);
    chk("t5_pend_rst", int'(pend_A), 0);
    chk("t5_done_rst", int'(done_A), 0);
    chk("t5_q_empty_rst", expq.size(), 0);
    tick(); tick();
    chk("t5_pend_hold", int'(pend_A), 0);
    push(K_RST, 0, 1); push(K_WR, 0, DEPTH); push(K_DONE, 1, 1);
    start_ch(4'b0001);
    tick(); tick();
    strobe(4'b0001, FL + DEPTH);
    wait_idle("t5_idle", 50);
    chk("t5_q_empty", expq.size(), 0);

    tick(); tick();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/wf_capture_seq.md
# wf_capture_seq

Capture sequencer and arbiter that shares one IQ sampler write port among `NWF` waterfall CIC channels in the `adc_clk` domain. It takes per-channel capture requests, grants the sampler to one channel at a time in round-robin order, and resets the sampler. It then optionally discards CIC settling samples, gates exactly `DEPTH` decimated strobes into the sampler, and reports completion per channel. It sits between the per-channel CIC outputs and the shared sampler, replacing direct wiring of `wf_cic_avail` to the sampler write strobe.

## Interface
- `NWF`, 4: number of waterfall channels, 1..8.
- `DEPTH`, 1024: samples per capture, power of two, 2..8192.
- `FLUSH_N`, 8: CIC settling strobes discarded after sampler reset, 1..255; used only with the flush feature.
- `adc_clk`  in  1  sole clock.
- `rst_A`  in  1  reset, synchronous, active-high.
- `start_A`  in  NWF  per-channel one-cycle capture request.
- `contin_A`  in  NWF  per-channel continuous-mode level.
- `avail_A`  in  NWF  per-channel CIC output strobe.
- `samp_rst_A`  out  1  sampler write-side reset pulse.
- `samp_wr_A`  out  1  sampler write strobe.
- `samp_sel_A`  out  clog2(NWF) (min 1)  index of the channel whose IQ is muxed into the sampler.
- `done_A`  out  NWF  per-channel one-cycle completion pulse.
- `busy_A`  out  1  high while not in IDLE.
- `pend_A`  out  NWF  latched pending requests.

## Operation
- Pending register: `pend_A[k]` sets on `start_A[k]` and clears in the cycle its grant is taken. A start for a channel that is already pending is absorbed. A start for the channel currently owning the sampler sets pend again, which queues a re-capture.
- State machine states: IDLE, RST, FLUSH, CAP, FIN.
- IDLE: if `pend_A` is nonzero, pick the first set bit at or after `last+1` (mod NWF), load `samp_sel_A` and `last`, clear that pend bit, and go to RST.
- RST: `samp_rst_A`=1 for exactly one cycle. Zero the count. Go to FLUSH if the feature is enabled, otherwise CAP.
- FLUSH: count `avail_A[sel]` strobes with `samp_wr_A`=0. After the `FLUSH_N`-th strobe, zero the count and go to CAP.
- CAP: `samp_wr_A` = `avail_A[sel]` combinationally, with zero added latency. The count increments on each such strobe. On the strobe that makes the count equal `DEPTH`, go to FIN.
- FIN (one cycle): `done_A[sel]`=1.
  - If `contin_A[sel]`=1, zero the count and return to CAP with no sampler reset; the sampler wraps.
  - Otherwise go to IDLE.
- `avail_A` strobes from non-selected channels are ignored in all states.
- In FIN, a strobe on `avail_A[sel]` is dropped; this is one sample of gap per wrap in continuous mode.
- The count is clog2(DEPTH)+1 bits wide and never exceeds `DEPTH`.
- A continuous owner keeps the sampler until `contin_A[sel]` drops. The current capture then completes at its next `DEPTH` boundary. Other channels' requests stay pending.

## Timing
- Reset values:
  - state = IDLE
  - `samp_rst_A`=0, `samp_wr_A`=0, `samp_sel_A`=0, `done_A`=0, `busy_A`=0, `pend_A`=0
  - `last`=NWF-1, so channel 0 wins the first arbitration.
- `rst_A` mid-capture: next cycle is IDLE and all pend bits are cleared. No `done_A` is issued.
- Start-to-`samp_rst_A` latency from IDLE: `start_A` at cycle t sets pend at t+1. Arbitration happens at t+1, and `samp_rst_A` is high at t+2.
- `samp_wr_A` is only ever high in CAP.
- `start_A` and a grant clearing the same bit in the same cycle: the set wins, so the channel is re-queued.
- `rst_A` and `start_A` in the same cycle: reset wins.
- `busy_A` is registered state ≠ IDLE.

## Configuration
- `WF_CAPTURE_FLUSH_EN` defined: FLUSH state present. The first `FLUSH_N` strobes after each RST are discarded.
- Not defined: FLUSH state and its counter are removed, and RST goes directly to CAP. `FLUSH_N` is ignored. Continuous wraps never flush in either build.

## Test plan
- Single capture, NWF=4, DEPTH=16, FLUSH_N=4, flush enabled: `start_A`=0001, then `avail_A[0]` every 3rd cycle -> one `samp_rst_A` pulse, first 4 strobes dropped, exactly 16 `samp_wr_A`, one `done_A`=0001, `busy_A` low afterwards.
- Round-robin: start channels 0, 2 and 3 simultaneously from reset -> grants in order 0, 2, 3 (`samp_sel_A`=0, 2, 3), three `done_A` pulses in that order, `pend_A` ends 0000.
- Continuous: `contin_A[1]`=1, start channel 1, 40 strobes, DEPTH=16 -> `done_A[1]` pulses after write 16 and write 32, no second `samp_rst_A`. Drop `contin_A` after write 20 -> final done after write 32, then IDLE.
- Foreign strobes ignored: owner is channel 0, `avail_A`=1110 toggling constantly -> `samp_wr_A` stays 0 and the count does not move.
- Reset mid-capture after 7 writes -> next cycle `busy_A`=0, `pend_A`=0, no `done_A`. A new start then captures the full 16 writes.
- Flush disabled build: same stimulus as test 1 -> 16 writes begin at the first strobe after `samp_rst_A`.
